// File: rtl/fgen_burst_ctrl.sv
// rtl/fgen_burst_ctrl.sv - LUT slice sequencer with rate divider and burst control
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   cfg_valid, cfg_ready   : configuration handshake, accepted only while idle
//   cfg_div                : strobe spacing minus one
//   cfg_count              : waveform periods per burst, 0 = continuous
//   start, stop            : one-cycle run begin / end-at-period-boundary requests
//   slice_idx, slice_en    : LUT address and one-cycle read strobe
//   busy, done             : run in progress / one-cycle normal-end pulse
module fgen_burst_ctrl #(
  parameter int SLICES = 8,
  parameter int DIV_W  = 16,
  parameter int IDX_W  = $clog2(SLICES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [7:0]       cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic [IDX_W-1:0] slice_idx,
  output logic             slice_en,
  output logic             busy,
  output logic             done
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [DIV_W-1:0] ph_q, ph_d;        // divider phase of the current cycle
  logic [IDX_W-1:0] nidx_q, nidx_d;    // index the next strobe will present
  logic [7:0]       per_q, per_d;
  logic             stop_q, stop_d;
  logic [IDX_W-1:0] slice_idx_q, slice_idx_d;
  logic             slice_en_q, slice_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick, period_end, terminal;

  assign tick       = (state_q == S_RUN) && (ph_q == '0);
  assign period_end = tick && (nidx_q == LAST_IDX);
  // A pending or same-cycle stop only ever ends the run on a period boundary.
  assign terminal   = period_end &&
                      (((cnt_q != 8'd0) && ((per_q + 8'd1) == cnt_q)) || stop_q || stop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (terminal) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Config lands in div_q/cnt_q on the same edge that starts the run, and the
  // first RUN cycle only needs a cleared phase, so the new values are in place
  // before anything reads them.
  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    ph_d   = ph_q;
    nidx_d = nidx_q;
    per_d  = per_q;
    stop_d = stop_q;
    if (state_q == S_IDLE) begin
      if (cfg_valid) begin
        div_d = cfg_div;
        cnt_d = cfg_count;
      end
      if (start) begin
        ph_d   = '0;
        nidx_d = '0;
        per_d  = '0;
        stop_d = 1'b0;
      end
    end else begin
      stop_d = stop_q | stop;
      ph_d   = (ph_q == div_q) ? '0 : ph_q + DIV_W'(1);
      if (tick)       nidx_d = nidx_q + IDX_W'(1);
      if (period_end) per_d  = per_q + 8'd1;
      if (terminal) begin
        ph_d   = '0;
        nidx_d = '0;
      end
    end
  end

  // Outputs are registered, so they are derived from next-cycle state.
  always_comb begin
    busy_d      = (state_d == S_RUN);
    slice_en_d  = (state_d == S_RUN) && (ph_d == '0);
    done_d      = terminal;
    slice_idx_d = slice_idx_q;
    if (state_d != S_RUN) begin
      slice_idx_d = '0;
    end else if (slice_en_d) begin
      slice_idx_d = nidx_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= '0;
      cnt_q       <= '0;
      ph_q        <= '0;
      nidx_q      <= '0;
      per_q       <= '0;
      stop_q      <= 1'b0;
      slice_idx_q <= '0;
      slice_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      ph_q        <= ph_d;
      nidx_q      <= nidx_d;
      per_q       <= per_d;
      stop_q      <= stop_d;
      slice_idx_q <= slice_idx_d;
      slice_en_q  <= slice_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cfg_ready = (state_q == S_IDLE);
  assign slice_idx = slice_idx_q;
  assign slice_en  = slice_en_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
